// File: rtl/video_sync_follower_if.sv
// Bus bundle for video_sync_follower: timing programming, frame toggle
// input and the generated raster position, sync decodes and lock status.
interface video_sync_follower_if #(
  parameter int HW = 12,
  parameter int VW = 12
);
  logic          ce_pix;
  logic          sync_in;
  logic          lock_en;
  logic [HW-1:0] h_total;
  logic [VW-1:0] v_total;
  logic [HW-1:0] hs_start;
  logic [HW-1:0] hs_end;
  logic [HW-1:0] hbl_start;
  logic [HW-1:0] hbl_end;
  logic [VW-1:0] vs_start;
  logic [VW-1:0] vs_end;
  logic [VW-1:0] vbl_start;
  logic [VW-1:0] vbl_end;
  logic [HW-1:0] lock_h;
  logic [VW-1:0] lock_v;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          hs_out;
  logic          vs_out;
  logic          hbl_out;
  logic          vbl_out;
  logic          locked;
  logic [HW-1:0] err_h;

  modport master (
    output ce_pix, sync_in, lock_en,
    output h_total, v_total,
    output hs_start, hs_end, hbl_start, hbl_end,
    output vs_start, vs_end, vbl_start, vbl_end,
    output lock_h, lock_v,
    input  hcnt, vcnt, hs_out, vs_out, hbl_out, vbl_out, locked, err_h
  );

  modport slave (
    input  ce_pix, sync_in, lock_en,
    input  h_total, v_total,
    input  hs_start, hs_end, hbl_start, hbl_end,
    input  vs_start, vs_end, vbl_start, vbl_end,
    input  lock_h, lock_v,
    output hcnt, vcnt, hs_out, vs_out, hbl_out, vbl_out, locked, err_h
  );
endinterface

// File: rtl/video_sync_follower.sv
// Frame-locked raster generator: free-running h/v counters that snap to a
// programmed lock point on every sync_in toggle and report tracking status.
module video_sync_follower #(
  parameter int HW = 12,
  parameter int VW = 12
) (
  input logic                 clk,
  input logic                 reset_n,
  video_sync_follower_if.slave bus
);

  logic          sync_d_q,   sync_d_d;
  logic [HW-1:0] hcnt_q,     hcnt_d;
  logic [VW-1:0] vcnt_q,     vcnt_d;
  logic [HW-1:0] err_h_q,    err_h_d;
  logic [1:0]    lock_cnt_q, lock_cnt_d;
  logic [1:0]    miss_fr_q,  miss_fr_d;
  logic          ev_seen_q,  ev_seen_d;
  logic          locked_q,   locked_d;
  logic          hs_q,       hs_d;
  logic          vs_q,       vs_d;
  logic          hbl_q,      hbl_d;
  logic          vbl_q,      vbl_d;

  logic          ev;
  logic          lock_ev;
  logic          h_last;
  logic          v_last;
  logic          v_wrap;
  logic          hit;
  logic [HW-1:0] h_diff;
  logic [1:0]    miss_inc;

  always_comb begin
    sync_d_d = bus.sync_in;
    ev       = bus.sync_in ^ sync_d_q;
    lock_ev  = ev & bus.lock_en;
    // Using >= lets an out-of-range lock point fall back into the raster.
    h_last   = hcnt_q >= (bus.h_total - HW'(1));
    v_last   = vcnt_q >= (bus.v_total - VW'(1));
    v_wrap   = bus.ce_pix & h_last & v_last & ~lock_ev;
    h_diff   = hcnt_q - bus.lock_h;
    hit      = (vcnt_q == bus.lock_v) &&
               ((h_diff == '0) || (h_diff == HW'(1)) || (h_diff == '1));
  end

  always_comb begin
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    err_h_d = err_h_q;
    if (lock_ev) begin
      hcnt_d  = bus.lock_h;
      vcnt_d  = bus.lock_v;
      err_h_d = h_diff;
    end else if (bus.ce_pix) begin
      if (h_last) begin
        hcnt_d = '0;
        vcnt_d = v_last ? '0 : vcnt_q + VW'(1);
      end else begin
        hcnt_d = hcnt_q + HW'(1);
      end
    end
  end

  // ev_seen remembers whether any lock event landed since the last v-wrap.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    miss_fr_d  = miss_fr_q;
    ev_seen_d  = ev_seen_q;
    miss_inc   = miss_fr_q + 2'd1;
    if (!bus.lock_en) begin
      lock_cnt_d = '0;
      miss_fr_d  = '0;
      ev_seen_d  = 1'b0;
    end else if (lock_ev) begin
      ev_seen_d = 1'b1;
      miss_fr_d = '0;
      if (hit) begin
        lock_cnt_d = (lock_cnt_q == 2'd3) ? 2'd3 : lock_cnt_q + 2'd1;
      end else begin
        lock_cnt_d = '0;
      end
    end else if (v_wrap) begin
      if (ev_seen_q) begin
        ev_seen_d = 1'b0;
      end else if (miss_inc >= 2'd2) begin
        miss_fr_d  = '0;
        lock_cnt_d = '0;
      end else begin
        miss_fr_d = miss_inc;
      end
    end
  end

  always_comb begin
    locked_d = (lock_cnt_q == 2'd3);
    hs_d     = (hcnt_q >= bus.hs_start)  && (hcnt_q < bus.hs_end);
    hbl_d    = (hcnt_q >= bus.hbl_start) && (hcnt_q < bus.hbl_end);
    vs_d     = (vcnt_q >= bus.vs_start)  && (vcnt_q < bus.vs_end);
    vbl_d    = (vcnt_q >= bus.vbl_start) && (vcnt_q < bus.vbl_end);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_d_q   <= 1'b0;
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      err_h_q    <= '0;
      lock_cnt_q <= '0;
      miss_fr_q  <= '0;
      ev_seen_q  <= 1'b0;
      locked_q   <= 1'b0;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      hbl_q      <= 1'b0;
      vbl_q      <= 1'b0;
    end else begin
      sync_d_q   <= sync_d_d;
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      err_h_q    <= err_h_d;
      lock_cnt_q <= lock_cnt_d;
      miss_fr_q  <= miss_fr_d;
      ev_seen_q  <= ev_seen_d;
      locked_q   <= locked_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      hbl_q      <= hbl_d;
      vbl_q      <= vbl_d;
    end
  end

  assign bus.hcnt    = hcnt_q;
  assign bus.vcnt    = vcnt_q;
  assign bus.err_h   = err_h_q;
  assign bus.locked  = locked_q;
  assign bus.hs_out  = hs_q;
  assign bus.vs_out  = vs_q;
  assign bus.hbl_out = hbl_q;
  assign bus.vbl_out = vbl_q;

endmodule

// File: tb/tb_video_sync_follower.sv
// Randomised and scenario stimulus for video_sync_follower, checked every
// cycle against a behavioural raster/lock model held in integers.
module tb_video_sync_follower;
  localparam int HW   = 12;
  localparam int VW   = 12;
  localparam int MASK = 4095;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  video_sync_follower_if #(.HW(HW), .VW(VW)) vif ();

  video_sync_follower #(.HW(HW), .VW(VW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (vif)
  );

  int vectors     = 0;
  int miscompares = 0;

  int m_h, m_v, m_prev, m_err, m_lc, m_miss, m_seen, m_locked;
  int m_hs, m_vs, m_hbl, m_vbl;
  logic cur_sync = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic setTiming(input int ht, input int vt, input int hss, input int hse,
                           input int hbs, input int hbe, input int vss, input int vse,
                           input int vbs, input int vbe, input int lh, input int lv);
    vif.h_total   = HW'(ht);  vif.v_total   = VW'(vt);
    vif.hs_start  = HW'(hss); vif.hs_end    = HW'(hse);
    vif.hbl_start = HW'(hbs); vif.hbl_end   = HW'(hbe);
    vif.vs_start  = VW'(vss); vif.vs_end    = VW'(vse);
    vif.vbl_start = VW'(vbs); vif.vbl_end   = VW'(vbe);
    vif.lock_h    = HW'(lh);  vif.lock_v    = VW'(lv);
  endtask

  // Reference: position is a pair of integers stepped along a raster of
  // h_total x v_total, lock quality counted as consecutive tolerant hits.
  task automatic modelStep();
    int ev, diff, hit, wrapv, ht_last, vt_last;
    if (!reset_n) begin
      m_h = 0; m_v = 0; m_prev = 0; m_err = 0; m_lc = 0; m_miss = 0; m_seen = 0;
      m_locked = 0; m_hs = 0; m_vs = 0; m_hbl = 0; m_vbl = 0;
      return;
    end
    ev     = (int'(vif.sync_in) != m_prev);
    m_prev = int'(vif.sync_in);
    m_hs   = (m_h >= int'(vif.hs_start))  && (m_h < int'(vif.hs_end));
    m_hbl  = (m_h >= int'(vif.hbl_start)) && (m_h < int'(vif.hbl_end));
    m_vs   = (m_v >= int'(vif.vs_start))  && (m_v < int'(vif.vs_end));
    m_vbl  = (m_v >= int'(vif.vbl_start)) && (m_v < int'(vif.vbl_end));
    m_locked = (m_lc == 3);
    if (vif.lock_en && ev) begin
      diff   = (m_h - int'(vif.lock_h)) & MASK;
      hit    = (m_v == int'(vif.lock_v)) && (diff == 0 || diff == 1 || diff == MASK);
      m_err  = diff;
      m_lc   = hit ? ((m_lc < 3) ? m_lc + 1 : 3) : 0;
      m_miss = 0;
      m_seen = 1;
      m_h    = int'(vif.lock_h);
      m_v    = int'(vif.lock_v);
    end else begin
      wrapv   = 0;
      ht_last = (int'(vif.h_total) - 1) & MASK;
      vt_last = (int'(vif.v_total) - 1) & MASK;
      if (vif.ce_pix) begin
        if (m_h >= ht_last) begin
          m_h = 0;
          if (m_v >= vt_last) begin m_v = 0; wrapv = 1; end
          else m_v = m_v + 1;
        end else begin
          m_h = m_h + 1;
        end
      end
      if (!vif.lock_en) begin
        m_lc = 0; m_miss = 0; m_seen = 0;
      end else if (wrapv) begin
        if (m_seen) m_seen = 0;
        else begin
          m_miss = m_miss + 1;
          if (m_miss >= 2) begin m_miss = 0; m_lc = 0; end
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic rn, input logic ce, input logic sy, input logic le);
    reset_n     = rn;
    vif.ce_pix  = ce;
    vif.sync_in = sy;
    vif.lock_en = le;
    cur_sync    = sy;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("hcnt",   32'(vif.hcnt),    32'(m_h));
    checkOutput("vcnt",   32'(vif.vcnt),    32'(m_v));
    checkOutput("hs",     32'(vif.hs_out),  32'(m_hs));
    checkOutput("vs",     32'(vif.vs_out),  32'(m_vs));
    checkOutput("hbl",    32'(vif.hbl_out), 32'(m_hbl));
    checkOutput("vbl",    32'(vif.vbl_out), 32'(m_vbl));
    checkOutput("locked", 32'(vif.locked),  32'(m_locked));
    checkOutput("err_h",  32'(vif.err_h),   32'(m_err));
  endtask

  task automatic runPlain(input int n, input logic le);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, cur_sync, le);
  endtask

  task automatic toggleSync(input logic le);
    applyStimulus(1'b1, 1'b1, ~cur_sync, le);
  endtask

  // Four events spaced one frame plus one pixel apart land on the lock point.
  task automatic acquire();
    toggleSync(1'b1);
    for (int k = 0; k < 3; k++) begin
      runPlain(50, 1'b1);
      toggleSync(1'b1);
    end
  endtask

  initial begin
    int hs_cnt, vs_cnt, found, gap, ht, vt;
    logic ce_r, le_r;
    setTiming(10, 5, 2, 4, 8, 10, 1, 2, 4, 5, 3, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_hcnt", 32'(vif.hcnt), 0);
    checkOutput("rst_locked", 32'(vif.locked), 0);

    // Free run with lock disabled; stray toggles must be ignored.
    hs_cnt = 0; vs_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      hs_cnt += int'(vif.hs_out);
      vs_cnt += int'(vif.vs_out);
    end
    checkOutput("free_hs_per_frame", 32'(hs_cnt), 10);
    checkOutput("free_vs_per_frame", 32'(vs_cnt), 10);
    runPlain(70, 1'b0);

    runPlain($urandom_range(0, 49), 1'b1);
    acquire();
    applyStimulus(1'b1, 1'b1, cur_sync, 1'b1);
    checkOutput("acq_locked", 32'(vif.locked), 1);
    checkOutput("acq_err", 32'(vif.err_h), 0);

    runPlain(48, 1'b1);
    toggleSync(1'b1);
    checkOutput("tol_minus1", 32'(vif.err_h), 32'hFFF);
    runPlain(50, 1'b1);
    toggleSync(1'b1);
    runPlain(51, 1'b1);
    toggleSync(1'b1);
    checkOutput("tol_plus1", 32'(vif.err_h), 1);
    runPlain(52, 1'b1);
    toggleSync(1'b1);
    checkOutput("tol_plus2_err", 32'(vif.err_h), 2);
    checkOutput("tol_plus2_still", 32'(vif.locked), 1);
    applyStimulus(1'b1, 1'b1, cur_sync, 1'b1);
    checkOutput("tol_plus2_drop", 32'(vif.locked), 0);

    runPlain(49, 1'b1);
    acquire();
    runPlain(200, 1'b1);
    checkOutput("timeout_locked", 32'(vif.locked), 0);

    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (m_h == 9 && m_v == 4) found = 1;
      else applyStimulus(1'b1, 1'b1, cur_sync, 1'b1);
    end
    checkOutput("simul_found", 32'(found), 1);
    toggleSync(1'b1);
    checkOutput("simul_hcnt", 32'(vif.hcnt), 3);
    checkOutput("simul_vcnt", 32'(vif.vcnt), 1);

    runPlain(50, 1'b1);
    acquire();
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (vif.hs_out && vif.locked) found = 1;
      else applyStimulus(1'b1, 1'b1, cur_sync, 1'b1);
    end
    checkOutput("rst_mid_found", 32'(found), 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("rst_mid_hcnt", 32'(vif.hcnt), 0);
    checkOutput("rst_mid_hs", 32'(vif.hs_out), 0);
    checkOutput("rst_mid_locked", 32'(vif.locked), 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("rst_ev_hcnt", 32'(vif.hcnt), 3);
    checkOutput("rst_ev_vcnt", 32'(vif.vcnt), 1);
    runPlain(5, 1'b1);
    checkOutput("rst_single_ev", 32'(vif.hcnt), 8);

    // Random programming, pixel enables, toggle spacing and resets.
    for (int b = 0; b < 30; b++) begin
      ht = $urandom_range(3, 16);
      vt = $urandom_range(2, 6);
      setTiming(ht, vt, $urandom_range(0, ht + 1), $urandom_range(0, ht + 1),
                $urandom_range(0, ht + 1), $urandom_range(0, ht + 1),
                $urandom_range(0, vt), $urandom_range(0, vt),
                $urandom_range(0, vt), $urandom_range(0, vt),
                $urandom_range(0, ht), $urandom_range(0, vt));
      le_r = ($urandom_range(0, 4) != 0);
      gap  = 0;
      for (int i = 0; i < 120; i++) begin
        ce_r = (b % 2 == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
        gap++;
        if ((b % 2 == 0 && gap >= ht * vt + int'($urandom_range(0, 2))) ||
            (b % 2 == 1 && $urandom_range(0, 25) == 0)) begin
          gap = 0;
          applyStimulus(($urandom_range(0, 199) != 0), ce_r, ~cur_sync, le_r);
        end else begin
          applyStimulus(($urandom_range(0, 199) != 0), ce_r, cur_sync, le_r);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
